matmult_param: RTL and testbench

MATMULT_PARAM -- requirements
Module: matmult_param

---
 rtl/matmult_param.sv | 172 +++++++++++++++++
 tb/tb_matmult_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmult_param.sv
// matmult_param -- sequential signed matrix multiplier, C = A * B.
//
// A is M x K, B is K x N, and C is M x N. The block does one signed
// multiply-accumulate per clock. It steps k innermost, then j, then i.
// A job is accepted in IDLE when ready is high. LOAD then clears the
// counters. CALC runs for M*N*K cycles. FIN holds valid and c_flat until
// the consumer acknowledges with accept.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset; clears all state and storage
//   ready   start request, sampled only in IDLE
//   accept  result acknowledge, sampled only in FIN
//   valid   result available (registered, high only in FIN)
//   busy    high in LOAD or CALC
//   a_flat  A[i][k] at [(i*K+k)*DW +: DW]
//   b_flat  B[k][j] at [(k*N+j)*DW +: DW]
//   c_flat  C[i][j] at [(i*N+j)*ACCW +: ACCW]
//   ovf     sticky saturation flag for the current result
//
// Build option
//   MATMULT_SAT_EN  when defined, each accumulation saturates to the
//                   signed ACCW range and any clamp sets ovf. When not
//                   defined, accumulation wraps and ovf stays 0.
module matmult_param #(
    parameter int M    = 5,
    parameter int K    = 2,
    parameter int N    = 5,
    parameter int DW   = 32,
    parameter int ACCW = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ready,
    input  logic                  accept,
    output logic                  valid,
    output logic                  busy,
    input  logic [M*K*DW-1:0]     a_flat,
    input  logic [K*N*DW-1:0]     b_flat,
    output logic [M*N*ACCW-1:0]   c_flat,
    output logic                  ovf
);

    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;
    localparam int JW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CALC = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]             r_state;
    logic [M*K*DW-1:0]      r_a;
    logic [K*N*DW-1:0]      r_b;
    logic [M*N*ACCW-1:0]    r_c;
    logic [IW-1:0]          r_i;
    logic [JW-1:0]          r_j;
    logic [KW-1:0]          r_k;
    logic signed [ACCW-1:0] r_acc;
    logic                   r_valid;
    logic                   r_ovf;

    int                       w_aidx, w_bidx, w_cidx;
    logic signed [DW-1:0]     w_a, w_b;
    logic signed [2*DW-1:0]   w_prod;
    logic signed [ACCW-1:0]   w_prod_x, w_base, w_acc_next;
    logic                     w_clamp;
    logic                     w_last_i, w_last_j, w_last_k;
`ifdef MATMULT_SAT_EN
    logic signed [ACCW:0]     w_sum;
`endif

    assign w_last_i = (r_i == IW'(M - 1));
    assign w_last_j = (r_j == JW'(N - 1));
    assign w_last_k = (r_k == KW'(K - 1));

    always_comb begin
        w_aidx   = (int'(r_i) * K + int'(r_k)) * DW;
        w_bidx   = (int'(r_k) * N + int'(r_j)) * DW;
        w_cidx   = (int'(r_i) * N + int'(r_j)) * ACCW;
        w_a      = r_a[w_aidx +: DW];
        w_b      = r_b[w_bidx +: DW];
        w_prod   = $signed((2*DW)'(w_a)) * $signed((2*DW)'(w_b));
        // The full-width product is sign-extended to ACCW, or truncated
        // when ACCW is narrower than 2*DW.
        w_prod_x = $signed(ACCW'(w_prod));
        // The first term of every dot product starts from zero, so the
        // accumulator never has to be cleared between C elements.
        w_base   = (r_k == '0) ? '0 : r_acc;
`ifdef MATMULT_SAT_EN
        // Add with one guard bit. The sum overflowed if the top two bits
        // differ, and the guard bit gives the true sign.
        w_sum      = $signed({w_base[ACCW-1], w_base}) + $signed({w_prod_x[ACCW-1], w_prod_x});
        w_clamp    = (w_sum[ACCW] != w_sum[ACCW-1]);
        w_acc_next = w_sum[ACCW-1:0];
        if (w_clamp)
            w_acc_next = w_sum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
`else
        w_clamp    = 1'b0;
        w_acc_next = w_base + w_prod_x;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (ready) begin
                        r_a     <= a_flat;
                        r_b     <= b_flat;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_i     <= '0;
                    r_j     <= '0;
                    r_k     <= '0;
                    r_acc   <= '0;
                    r_ovf   <= 1'b0;
                    r_state <= S_CALC;
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_ovf <= r_ovf | w_clamp;
                    if (w_last_k) begin
                        r_c[w_cidx +: ACCW] <= w_acc_next;
                        r_k <= '0;
                        if (w_last_j) begin
                            r_j <= '0;
                            if (w_last_i) begin
                                r_i     <= '0;
                                r_state <= S_FIN;
                                r_valid <= 1'b1;
                            end else begin
                                r_i <= r_i + IW'(1);
                            end
                        end else begin
                            r_j <= r_j + JW'(1);
                        end
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_FIN: begin
                    if (accept) begin
                        r_state <= S_IDLE;
                        r_valid <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign valid  = r_valid;
    assign busy   = (r_state == S_LOAD) || (r_state == S_CALC);
    assign c_flat = r_c;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_matmult_param.sv
// tb_matmult_param -- self-checking bench for matmult_param.
// The main instance uses the default sizes. It is checked every cycle
// against a cycle-count and arithmetic reference model. Two small
// instances cover the DW=8/ACCW=16 saturation case and the 1x1x1 case.
module tb_matmult_param;

    localparam int M = 5, K = 2, N = 5, DW = 32, AW = 64;
    localparam int MNK = M * N * K;
`ifdef MATMULT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic signed [127:0] MAXV = 128'sh7fff_ffff_ffff_ffff;
    localparam logic signed [127:0] MINV = -MAXV - 128'sd1;

    logic                clk = 1'b0;
    logic                rst, ready, accept;
    logic                valid, busy, ovf;
    logic [M*K*DW-1:0]   a_flat;
    logic [K*N*DW-1:0]   b_flat;
    logic [M*N*AW-1:0]   c_flat;

    // Small instance: 1x4 by 4x1, 8-bit operands, 16-bit accumulator.
    logic        s_ready, s_accept, s_valid, s_busy, s_ovf;
    logic [31:0] s_a, s_b;
    logic [15:0] s_c;
    // Smallest instance: 1x1x1.
    logic        p_ready, p_accept, p_valid, p_busy, p_ovf;
    logic [7:0]  p_a, p_b;
    logic [15:0] p_c;

    always #5 clk = ~clk;

    matmult_param #(.M(M), .K(K), .N(N), .DW(DW), .ACCW(AW)) u_dut (
        .clk(clk), .rst(rst), .ready(ready), .accept(accept),
        .valid(valid), .busy(busy), .a_flat(a_flat), .b_flat(b_flat),
        .c_flat(c_flat), .ovf(ovf));

    matmult_param #(.M(1), .K(4), .N(1), .DW(8), .ACCW(16)) u_sat (
        .clk(clk), .rst(rst), .ready(s_ready), .accept(s_accept),
        .valid(s_valid), .busy(s_busy), .a_flat(s_a), .b_flat(s_b),
        .c_flat(s_c), .ovf(s_ovf));

    matmult_param #(.M(1), .K(1), .N(1), .DW(8), .ACCW(16)) u_one (
        .clk(clk), .rst(rst), .ready(p_ready), .accept(p_accept),
        .valid(p_valid), .busy(p_busy), .a_flat(p_a), .b_flat(p_b),
        .c_flat(p_c), .ovf(p_ovf));

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic longint cel(input logic [M*N*AW-1:0] c, input int i, input int j);
        return $signed(c[(i*N+j)*AW +: AW]);
    endfunction

    // Reference: plain dot products on the captured operands.
    // Saturation or wrap is applied after every add.
    task automatic ref_mm(input logic [M*K*DW-1:0] a, input logic [K*N*DW-1:0] b,
                          output logic [M*N*AW-1:0] c, output bit o);
        longint acc, av, bv;
        logic signed [127:0] s;
        c = '0;
        o = 1'b0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                acc = 0;
                for (int k = 0; k < K; k++) begin
                    av = longint'($signed(a[(i*K+k)*DW +: DW]));
                    bv = longint'($signed(b[(k*N+j)*DW +: DW]));
                    s  = $signed(128'(acc)) + $signed(128'(av * bv));
                    if (SAT && s > MAXV) begin acc = 64'h7fff_ffff_ffff_ffff; o = 1'b1; end
                    else if (SAT && s < MINV) begin acc = 64'h8000_0000_0000_0000; o = 1'b1; end
                    else acc = s[63:0];
                end
                c[(i*N+j)*AW +: AW] = acc;
            end
    endtask

    // Cycle model: m_t counts edges since the capture edge while a job runs.
    int                 m_t = -1;
    bit                 m_valid = 1'b0, m_ovf = 1'b0, m_rovf;
    logic [M*N*AW-1:0]  m_c = '0, m_res;
    bit                 chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_t = -1; m_valid = 1'b0; m_c = '0; m_ovf = 1'b0;
        end else if (m_t >= 0) begin
            m_t++;
            if (m_t == MNK + 1) begin
                m_valid = 1'b1; m_c = m_res; m_ovf = m_rovf; m_t = -1;
            end
        end else if (m_valid) begin
            if (accept) m_valid = 1'b0;
        end else if (ready) begin
            ref_mm(a_flat, b_flat, m_res, m_rovf);
            m_t = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int e;
            chk("valid", 64'(valid), 64'(m_valid));
            chk("busy", 64'(busy), 64'(m_t >= 0));
            if (m_t < 0) begin
                e = 0;
                for (int q = M*N-1; q >= 0; q--)
                    if (c_flat[q*AW +: AW] !== m_c[q*AW +: AW]) e = q;
                chk("c_flat", c_flat[e*AW +: AW], m_c[e*AW +: AW]);
                chk("ovf", 64'(ovf), 64'(m_ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_op();
        int v;
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'h7fff_ffff;
            default: begin
                v = int'($urandom_range(0, 2000)) - 1000;
                return 32'(v);
            end
        endcase
    endfunction

    // One job: capture, wait for valid, hold FIN while disturbing inputs,
    // accept, then leave one idle cycle.
    task automatic run_op(input logic [M*K*DW-1:0] a, input logic [K*N*DW-1:0] b,
                          input int hold, output int cyc, output int bc);
        int n;
        a_flat = a; b_flat = b; ready = 1'b1;
        tick();
        ready = 1'b0;
        bc = busy ? 1 : 0;
        n = 0;
        while (!valid && n < 200) begin
            tick();
            n++;
            if (busy) bc++;
        end
        cyc = n + 1;
        if (!valid) chk("valid_timeout", 64'd0, 64'd1);
        for (int h = 0; h < hold; h++) begin
            ready = 1'($urandom_range(0, 1));
            for (int q = 0; q < M*K; q++) a_flat[q*DW +: DW] = rnd_op();
            tick();
        end
        ready = 1'b0; accept = 1'b1;
        tick();
        accept = 1'b0;
        tick();
    endtask

    initial begin
        logic [M*K*DW-1:0] a;
        logic [K*N*DW-1:0] b;
        logic [M*N*AW-1:0] rc;
        bit ro;
        int cyc, bc, n;

        rst = 1'b1; ready = 1'b0; accept = 1'b0; a_flat = '0; b_flat = '0;
        s_ready = 1'b0; s_accept = 1'b0; s_a = '0; s_b = '0;
        p_ready = 1'b0; p_accept = 1'b0; p_a = '0; p_b = '0;
        repeat (3) tick();
        rst = 1'b0;
        chk_en = 1'b1;
        tick();
        chk("rst_c", c_flat[63:0], 64'd0);

        // A all 1, B all 2: every element is 4, valid at cycle 52,
        // and busy for 51 cycles.
        for (int q = 0; q < M*K; q++) a[q*DW +: DW] = 32'd1;
        for (int q = 0; q < K*N; q++) b[q*DW +: DW] = 32'd2;
        ref_mm(a, b, rc, ro);
        chk("model_ones", 64'(cel(rc, 2, 3)), 64'd4);
        run_op(a, b, 0, cyc, bc);
        chk("valid_cycle", 64'(cyc), 64'd52);
        chk("busy_cycles", 64'(bc), 64'd51);
        chk("c_ones", 64'(cel(c_flat, 4, 4)), 64'd4);

        // A all -3, B all 7: every element is -42. FIN is held for 10 cycles.
        for (int q = 0; q < M*K; q++) a[q*DW +: DW] = -32'sd3;
        for (int q = 0; q < K*N; q++) b[q*DW +: DW] = 32'sd7;
        ref_mm(a, b, rc, ro);
        chk("model_neg", 64'(cel(rc, 1, 2)), 64'(-64'sd42));
        run_op(a, b, 10, cyc, bc);
        chk("c_neg", 64'(cel(c_flat, 0, 0)), 64'(-64'sd42));

        // A[i][0]=i and A[i][1]=0, with B[0][j]=j: C[i][j] = i*j.
        for (int i = 0; i < M; i++) begin
            a[(i*K+0)*DW +: DW] = 32'(i);
            a[(i*K+1)*DW +: DW] = 32'd0;
        end
        for (int j = 0; j < N; j++) begin
            b[(0*N+j)*DW +: DW] = 32'(j);
            b[(1*N+j)*DW +: DW] = $urandom;
        end
        ref_mm(a, b, rc, ro);
        chk("model_ij", 64'(cel(rc, 3, 4)), 64'd12);
        run_op(a, b, 2, cyc, bc);
        chk("c_ij", 64'(cel(c_flat, 4, 3)), 64'd12);

        // Reset in CALC cycle 20 aborts the job. A fresh job still works.
        for (int q = 0; q < M*K; q++) a_flat[q*DW +: DW] = rnd_op();
        for (int q = 0; q < K*N; q++) b_flat[q*DW +: DW] = rnd_op();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        repeat (21) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_c", c_flat[M*N*AW-1 -: 64], 64'd0);
        tick();

        // Random jobs, including extreme operands.
        for (int r = 0; r < 6; r++) begin
            for (int q = 0; q < M*K; q++) a[q*DW +: DW] = rnd_op();
            for (int q = 0; q < K*N; q++) b[q*DW +: DW] = rnd_op();
            run_op(a, b, int'($urandom_range(0, 4)), cyc, bc);
            chk("valid_cycle_rnd", 64'(cyc), 64'(MNK + 2));
        end

        // DW=8, ACCW=16, K=4, with all operands 127.
        s_a = {4{8'd127}}; s_b = {4{8'd127}}; s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        n = 0;
        while (!s_valid && n < 100) begin tick(); n++; end
        chk("sat_valid", 64'(s_valid), 64'd1);
        chk("sat_c", 64'($signed(s_c)), SAT ? 64'd32767 : 64'(-64'sd1020));
        chk("sat_ovf", 64'(s_ovf), 64'(SAT));
        s_accept = 1'b1;
        tick();
        s_accept = 1'b0;
        tick();
        chk("sat_valid_drop", 64'(s_valid), 64'd0);

        // 1x1x1 case: 5 * -6 = -30, with valid at cycle 3.
        p_a = 8'd5; p_b = 8'hFA; p_ready = 1'b1;
        tick();
        p_ready = 1'b0;
        n = 0;
        while (!p_valid && n < 100) begin tick(); n++; end
        chk("one_cycle", 64'(n + 1), 64'd3);
        chk("one_c", 64'($signed(p_c)), 64'(-64'sd30));
        p_accept = 1'b1;
        tick();
        p_accept = 1'b0;
        tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
